// File: rtl/iz_pkg.sv
// Shared types and constants for the Izhikevich neuron scheduler.
// State words are 22-bit sign-magnitude, bit 21 carries the sign.
package iz_pkg;

    localparam int STATE_W = 22;

    typedef logic [STATE_W-1:0] iz_state_t;
    typedef logic [2:0]         iz_type_t;
    typedef logic [4:0]         iz_cur_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } sched_state_t;

    // Neuron type encodings; types 0-3 use b=0.2, the rest b=0.25
    localparam iz_type_t TYPE_RS  = 3'd0;
    localparam iz_type_t TYPE_IB  = 3'd1;
    localparam iz_type_t TYPE_CH  = 3'd2;
    localparam iz_type_t TYPE_FS  = 3'd3;
    localparam iz_type_t TYPE_TC  = 3'd4;
    localparam iz_type_t TYPE_RZ  = 3'd5;
    localparam iz_type_t TYPE_LTS = 3'd6;
    localparam iz_type_t TYPE_AUX = 3'd7;

    // V = -65, U = b*V for the two recovery slopes
    localparam iz_state_t V_INIT      = 22'h229999;
    localparam iz_state_t U_INIT_B020 = 22'h20851E;
    localparam iz_state_t U_INIT_B025 = 22'h20A666;

    function automatic iz_state_t u_init(input iz_type_t t);
        return (t <= TYPE_FS) ? U_INIT_B020 : U_INIT_B025;
    endfunction

endpackage

// File: rtl/iz_neuron_scheduler_if.sv
// Engine command/result bus and spike-event stream of the scheduler.
// master = scheduler side, slave = engine / event consumer side.
interface iz_neuron_scheduler_if
    import iz_pkg::*;
#(
    parameter int IDX_W = 3
) ();

    logic             eng_start;
    iz_state_t        eng_v;
    iz_state_t        eng_u;
    iz_type_t         eng_type;
    iz_cur_t          eng_cur;
    logic             eng_done;
    iz_state_t        eng_v_next;
    iz_state_t        eng_u_next;
    logic             eng_spike;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_idx;
    logic             spike_ready;

    modport master (
        output eng_start,
        output eng_v,
        output eng_u,
        output eng_type,
        output eng_cur,
        input  eng_done,
        input  eng_v_next,
        input  eng_u_next,
        input  eng_spike,
        output spike_valid,
        output spike_idx,
        input  spike_ready
    );

    modport slave (
        input  eng_start,
        input  eng_v,
        input  eng_u,
        input  eng_type,
        input  eng_cur,
        output eng_done,
        output eng_v_next,
        output eng_u_next,
        output eng_spike,
        input  spike_valid,
        input  spike_idx,
        output spike_ready
    );

endinterface

// File: rtl/iz_spike_fifo.sv
// Spike-event FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle, otherwise it is dropped and flagged.
module iz_spike_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage array, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with extra wrap bit for full/empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iz_neuron_scheduler.sv
// Time-multiplexed Izhikevich neuron scheduler: sweeps all neurons
// through an external engine. Optional: IZ_SCHED_STATS_EN (spike_count).
module iz_neuron_scheduler
    import iz_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_NEURONS)-1:0] cfg_idx,
    input  iz_type_t                       cfg_type,
    input  iz_cur_t                        cfg_cur,
    iz_neuron_scheduler_if.master          bus,
    output logic                           busy,
    output logic                           overflow,
    output logic [7:0]                     tick_miss
`ifdef IZ_SCHED_STATS_EN
    ,
    output logic [15:0]                    spike_count
`endif
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    sched_state_t     state;
    sched_state_t     state_nx;
    logic [IDX_W-1:0] idx;

    iz_state_t v_mem [NUM_NEURONS];
    iz_state_t u_mem [NUM_NEURONS];
    iz_type_t  t_mem [NUM_NEURONS];
    iz_cur_t   c_mem [NUM_NEURONS];

    iz_state_t v_hold;
    iz_state_t u_hold;
    iz_type_t  t_hold;
    iz_cur_t   c_hold;

    iz_state_t v_res;
    iz_state_t u_res;
    logic      spike_res;

    logic cfg_hit;
    logic issuing;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_empty;
    logic fifo_full;
    logic fifo_drop;

    assign cfg_hit = cfg_we && (32'(cfg_idx) < NUM_NEURONS);
    assign issuing = (state == ST_ISSUE);
    assign busy    = (state != ST_IDLE);

    // In ISSUE present the neuron directly; afterwards hold the snapshot
    assign bus.eng_start = issuing;
    assign bus.eng_v     = issuing ? v_mem[idx] : v_hold;
    assign bus.eng_u     = issuing ? u_mem[idx] : u_hold;
    assign bus.eng_type  = issuing ? t_mem[idx] : t_hold;
    assign bus.eng_cur   = issuing ? c_mem[idx] : c_hold;

    // Sweep sequencing: one ISSUE/WAIT/WRITE round per neuron
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (tick) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (bus.eng_done) state_nx = ST_WRITE;
            ST_WRITE: state_nx = (idx == LAST) ? ST_IDLE : ST_ISSUE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State register and neuron index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && tick) begin
                idx <= '0;
            end else if (state == ST_WRITE && idx != LAST) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Command snapshot at ISSUE and engine result capture at done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_hold    <= '0;
            u_hold    <= '0;
            t_hold    <= '0;
            c_hold    <= '0;
            v_res     <= '0;
            u_res     <= '0;
            spike_res <= 1'b0;
        end else begin
            if (issuing) begin
                v_hold <= v_mem[idx];
                u_hold <= u_mem[idx];
                t_hold <= t_mem[idx];
                c_hold <= c_mem[idx];
            end
            if (state == ST_WAIT && bus.eng_done) begin
                v_res     <= bus.eng_v_next;
                u_res     <= bus.eng_u_next;
                spike_res <= bus.eng_spike;
            end
        end
    end

    // Neuron state table: config writes and sweep write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i] <= V_INIT;
                u_mem[i] <= U_INIT_B020;
                t_mem[i] <= TYPE_RS;
                c_mem[i] <= '0;
            end
        end else begin
            if (cfg_hit) begin
                c_mem[cfg_idx] <= cfg_cur;
                if (state == ST_IDLE) begin
                    t_mem[cfg_idx] <= cfg_type;
                    v_mem[cfg_idx] <= V_INIT;
                    u_mem[cfg_idx] <= u_init(cfg_type);
                end
            end
            if (state == ST_WRITE) begin
                v_mem[idx] <= v_res;
                u_mem[idx] <= u_res;
            end
        end
    end

    // Ticks arriving mid-sweep are counted, never queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_miss <= '0;
        end else if (busy && tick && tick_miss != 8'hFF) begin
            tick_miss <= tick_miss + 8'd1;
        end
    end

    assign fifo_push       = (state == ST_WRITE) && spike_res;
    assign fifo_pop        = bus.spike_valid && bus.spike_ready;
    assign bus.spike_valid = !fifo_empty;

    iz_spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (idx),
        .pop       (fifo_pop),
        .pop_data  (bus.spike_idx),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    // Sticky flag for any spike event lost to a full FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef IZ_SCHED_STATS_EN
    // Every spike reported by the engine, dropped or not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_count <= '0;
        end else if (fifo_push && spike_count != 16'hFFFF) begin
            spike_count <= spike_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/iz_neuron_scheduler.md
IZ_NEURON_SCHEDULER -- requirements
Module: iz_neuron_scheduler

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 8, number of time-multiplexed neurons (power of 2, 2..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, spike-event FIFO entries (power of 2).
REQ-003 SHALL have clk  input  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-004 SHALL have rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have tick  input  1  one-cycle pulse starting one update sweep over all neurons.
REQ-006 SHALL have cfg_we, cfg_idx, cfg_type, cfg_cur  input  1/log2(N)/3/5  write neuron type and input current.
REQ-007 SHALL have eng_start  output  1 and eng_v, eng_u  output  22 and eng_type  output  3 and eng_cur  output  5  engine command.
REQ-008 SHALL have eng_done  input  1 and eng_v_next, eng_u_next  input  22 and eng_spike  input  1  engine result.
REQ-009 SHALL have spike_valid  output  1, spike_idx  output  log2(N), spike_ready  input  1  spike-event stream.
REQ-010 SHALL have busy  output  1, overflow  output  1 (sticky), tick_miss  output  8 (saturating).

Function
REQ-011 SHALL hold per neuron: V, U (22-bit sign-magnitude, bit 21 sign), type (3b), cur (5b).
REQ-012 SHALL use FSM IDLE -> ISSUE -> WAIT -> WRITE -> (next idx ISSUE | last idx IDLE).
REQ-013 IDLE: on tick, set idx=0, busy=1, go ISSUE next cycle.
REQ-014 ISSUE: drive eng_* from state of idx, pulse eng_start exactly one cycle; go WAIT.
REQ-015 WAIT: hold eng_v/eng_u/eng_type/eng_cur stable until eng_done; eng_done in same cycle as eng_start is ignored.
REQ-016 WRITE: store eng_v_next/eng_u_next (sampled at eng_done) into idx; if eng_spike, push idx to FIFO.
REQ-017 Sweep latency SHALL be NUM_NEURONS*(3+engine_latency) cycles from tick to busy=0.
REQ-018 busy SHALL be 1 from the cycle after tick through the last WRITE, 0 in IDLE.
REQ-019 tick while busy SHALL be ignored and increment tick_miss, saturating at 255.
REQ-020 FIFO push when full SHALL drop the event and set overflow until reset.
REQ-021 spike_valid = FIFO non-empty; pop on spike_valid && spike_ready; simultaneous push and pop when full SHALL succeed without overflow.
REQ-022 cfg_we in IDLE SHALL write type/cur and reinitialize V=22'h229999, U per type (b=0.2 types 0-3: 22'h20851E; else 22'h20A666).
REQ-023 cfg_we while busy SHALL update cur only; type/V/U change deferred to never (write ignored for type), cur takes effect on that neuron's next ISSUE.
REQ-024 cfg_idx out of range SHALL be ignored.

Reset
REQ-025 On rst: FSM IDLE, idx=0, eng_start=0, eng_* data=0, busy=0, overflow=0, tick_miss=0, FIFO empty, spike_valid=0.
REQ-026 On rst: every neuron type=0, cur=0, V=22'h229999, U=22'h20851E.
REQ-027 rst asserted mid-sweep SHALL abort immediately; a later eng_done SHALL be ignored unless in WAIT.

Configuration
REQ-028 Macro IZ_SCHED_STATS_EN defined: add output spike_count 16-bit, counting FIFO pushes (including dropped), saturating, reset 0.
REQ-029 Macro undefined: no spike_count port, no counter logic.

Structure
REQ-030 Shared package iz_pkg SHALL hold the 22-bit state typedef, FSM state enum, type encodings, and initial V/U constants.
REQ-031 Sub-module iz_spike_fifo (parameterized depth, width log2(N)) SHALL implement the event FIFO.

Verification
REQ-032 Reset, tick, engine returns done after 2 cycles, no spikes, N=8 -> 8 eng_start pulses, busy high 40 cycles, no spike_valid.
REQ-033 Engine asserts eng_spike for idx 3 and 5, spike_ready=1 -> spike_idx 3 then 5, overflow=0.
REQ-034 spike_ready=0, engine spikes every neuron -> 4 events held, overflow=1, drain yields 0,1,2,3.
REQ-035 Tick pulses 3 times during one sweep -> tick_miss=3, only one sweep performed.
REQ-036 cfg_we idx=2 type=4 cur=10 in IDLE, then tick -> ISSUE idx 2 shows eng_type=4, eng_cur=10, eng_u=22'h20A666, eng_v=22'h229999.
REQ-037 rst asserted in WAIT of idx 4 -> all outputs at reset values next cycle, stale eng_done has no effect.
